// File: rtl/cache_pkg.sv
// Shared types for the cache requester: bus widths, FSM states and the latched CPU request.
package cache_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TMO_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    C_RD,
    C_RD_CHK,
    C_WR,
    C_WR_WAIT,
    MEM_REQ,
    MEM_WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/cache_req_timeout.sv
// Loadable down-counter; expired is high on the last allowed cycle. A load value of 0 never expires.
module cache_req_timeout #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == W'(1));

endmodule

// File: rtl/cache_requester.sv
// Sole master of the two-entry cache port: serves CPU loads/stores, fills on read miss, writes through on stores.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid holds until then.
module cache_requester
  import cache_pkg::*;
#(
  parameter int ADDR_W    = cache_pkg::ADDR_W,
  parameter int DATA_W    = cache_pkg::DATA_W,
  parameter int CWAIT_MAX = 8,
  parameter int MWAIT_MAX = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_data,
  output logic              cpu_rsp_valid,
  input  logic              cpu_rsp_ready,
  output logic [DATA_W-1:0] cpu_rsp_data,
  output logic              cpu_rsp_hit,
  output logic              cpu_rsp_err,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_val,
  output logic              c_read,
  output logic              c_write,
  input  logic              c_hit,
  input  logic [DATA_W-1:0] c_out_val,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output state_e            dbg_state
);

  state_e state;
  req_t   req;
  logic   err;
  logic   resident;
  logic   wr_first;
  logic   cw_expired;
  logic   mw_expired;

  assign dbg_state = state;

  // C_WR and MEM_REQ each precede their wait state, so they double as the counter load strobes.
  cache_req_timeout #(.W(TMO_W)) u_cwait (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (state == C_WR),
    .load_val (TMO_W'(CWAIT_MAX)),
    .tick     (state == C_WR_WAIT),
    .expired  (cw_expired)
  );

  cache_req_timeout #(.W(TMO_W)) u_mwait (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (state == MEM_REQ),
    .load_val (TMO_W'(MWAIT_MAX)),
    .tick     (state == MEM_WAIT),
    .expired  (mw_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      req           <= '0;
      err           <= 1'b0;
      resident      <= 1'b0;
      wr_first      <= 1'b0;
      cpu_req_ready <= 1'b1;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_data  <= '0;
      cpu_rsp_hit   <= 1'b0;
      cpu_rsp_err   <= 1'b0;
      c_addr        <= '0;
      c_val         <= '0;
      c_read        <= 1'b0;
      c_write       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid && cpu_req_ready) begin
            req.write     <= cpu_req_write;
            req.addr      <= cpu_req_addr;
            req.data      <= cpu_req_data;
            err           <= 1'b0;
            resident      <= 1'b0;
            cpu_req_ready <= 1'b0;
            c_addr        <= cpu_req_addr;
            if (cpu_req_write) begin
              c_val   <= cpu_req_data;
              c_write <= 1'b1;
              state   <= C_WR;
            end else begin
              c_read <= 1'b1;
              state  <= C_RD;
            end
          end
        end
        C_RD: begin
          c_read <= 1'b0;
          state  <= C_RD_CHK;
        end
        C_RD_CHK: begin
          if (c_hit) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_data  <= c_out_val;
            cpu_rsp_hit   <= 1'b1;
            state         <= RESP;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b0;
            mem_req_addr  <= req.addr;
            mem_req_data  <= '0;
            state         <= MEM_REQ;
          end
        end
        C_WR: begin
          wr_first <= 1'b1;
          state    <= C_WR_WAIT;
        end
        C_WR_WAIT: begin
          wr_first <= 1'b0;
          // The first hit sample reflects residency before this write allocated the line.
          if (wr_first && req.write) resident <= c_hit;
          if (c_hit || cw_expired) begin
            c_write <= 1'b0;
            if (!c_hit) err <= 1'b1;
            if (req.write) begin
              mem_req_valid <= 1'b1;
              mem_req_write <= 1'b1;
              mem_req_addr  <= req.addr;
              mem_req_data  <= req.data;
              state         <= MEM_REQ;
            end else begin
              cpu_rsp_valid <= 1'b1;
              cpu_rsp_data  <= req.data;
              cpu_rsp_hit   <= 1'b0;
              cpu_rsp_err   <= err | ~c_hit;
              state         <= RESP;
            end
          end
        end
        MEM_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            if (mem_req_write) begin
              cpu_rsp_valid <= 1'b1;
              cpu_rsp_data  <= '0;
              cpu_rsp_hit   <= resident;
              cpu_rsp_err   <= err;
              state         <= RESP;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_rsp_valid) begin
            req.data <= mem_rsp_data;
            c_addr   <= req.addr;
            c_val    <= mem_rsp_data;
            c_write  <= 1'b1;
            state    <= C_WR;
          end else if (mw_expired) begin
            err           <= 1'b1;
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_data  <= '0;
            cpu_rsp_hit   <= 1'b0;
            cpu_rsp_err   <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (cpu_rsp_ready) begin
            cpu_rsp_valid <= 1'b0;
            cpu_rsp_data  <= '0;
            cpu_rsp_hit   <= 1'b0;
            cpu_rsp_err   <= 1'b0;
            cpu_req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester: behavioural two-entry cache and memory, transaction-level reference model.
module tb_cache_requester;
  import cache_pkg::*;

  localparam int CWAIT = 8;
  localparam int MWAIT = 8;

  logic              clock;
  logic              reset_n;
  logic              cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_data;
  logic              cpu_rsp_valid, cpu_rsp_ready, cpu_rsp_hit, cpu_rsp_err;
  logic [DATA_W-1:0] cpu_rsp_data;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_val, c_out_val;
  logic              c_read, c_write, c_hit;
  logic              mem_req_valid, mem_req_ready, mem_req_write, mem_rsp_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data, mem_rsp_data;
  state_e            dbg_state;

  cache_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CWAIT_MAX(CWAIT), .MWAIT_MAX(MWAIT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready), .cpu_rsp_data(cpu_rsp_data),
    .cpu_rsp_hit(cpu_rsp_hit), .cpu_rsp_err(cpu_rsp_err),
    .c_addr(c_addr), .c_val(c_val), .c_read(c_read), .c_write(c_write),
    .c_hit(c_hit), .c_out_val(c_out_val),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- cache environment model ----------------
  logic              cv [2];
  logic [ADDR_W-1:0] ctag [2];
  logic [DATA_W-1:0] cdat [2];
  int                cvict;
  bit                cache_stuck;

  always @(posedge clock) begin
    logic rd, wr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    int idx;
    rd = c_read; wr = c_write; a = c_addr; v = c_val;
    #1;
    if (!reset_n) begin
      cv[0] = 1'b0; cv[1] = 1'b0; cvict = 0; c_hit = 1'b0; c_out_val = '0;
    end else begin
      idx = -1;
      for (int i = 0; i < 2; i++) if (cv[i] && ctag[i] == a) idx = i;
      if (rd) begin
        c_hit     = (idx >= 0);
        c_out_val = (idx >= 0) ? cdat[idx] : '0;
      end else if (wr) begin
        if (cache_stuck) c_hit = 1'b0;
        else if (idx >= 0) begin
          cdat[idx] = v; c_hit = 1'b1;
        end else begin
          cv[cvict] = 1'b1; ctag[cvict] = a; cdat[cvict] = v; cvict = 1 - cvict; c_hit = 1'b0;
        end
      end
    end
  end

  // ---------------- memory environment model ----------------
  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } mop_t;

  logic [DATA_W-1:0] mem [256];
  mop_t              obs_q[$];
  bit                mem_dead, rdy_rand;
  int                lat_cfg;
  bit                rd_pend;
  int                rd_left;
  logic [ADDR_W-1:0] rd_addr;

  always @(posedge clock) begin
    logic acc;
    mop_t op;
    acc  = mem_req_valid && mem_req_ready;
    op.w = mem_req_write; op.a = mem_req_addr; op.d = mem_req_data;
    #1;
    mem_rsp_valid = 1'b0;
    if (!reset_n) rd_pend = 1'b0;
    else begin
      if (rd_pend) begin
        if (rd_left == 0) begin
          mem_rsp_valid = 1'b1; mem_rsp_data = mem[rd_addr]; rd_pend = 1'b0;
        end else rd_left--;
      end
      if (acc) begin
        obs_q.push_back(op);
        if (op.w) mem[op.a] = op.d;
        else if (!mem_dead) begin
          rd_pend = 1'b1; rd_addr = op.a;
          rd_left = ((lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 5))) - 1;
        end
      end
    end
    mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [256];
  logic [ADDR_W-1:0] ref_lines[$];
  logic [DATA_W+1:0] exp_q[$];
  logic [DATA_W+1:0] last_rsp;
  bit                busy, mon_on;
  int                cw_cycles;

  function automatic bit is_res(input logic [ADDR_W-1:0] a);
    foreach (ref_lines[i]) if (ref_lines[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void add_line(input logic [ADDR_W-1:0] a);
    ref_lines.push_back(a);
    if (ref_lines.size() > 2) void'(ref_lines.pop_front());
  endfunction

  // Compare process: invariants and response contents on every cycle.
  always @(negedge clock) begin
    if (reset_n && mon_on) begin
      if (c_write) cw_cycles++;
      chk("strobe_excl", 64'(c_read & c_write), 64'(0));
      chk("req_ready", 64'(cpu_req_ready), 64'(!busy));
      if (cpu_rsp_valid) begin
        last_rsp = {cpu_rsp_data, cpu_rsp_hit, cpu_rsp_err};
        chk("rsp_pending", 64'(exp_q.size()), 64'(1));
        if (exp_q.size() > 0) chk("rsp", 64'(last_rsp), 64'(exp_q[0]));
      end else begin
        chk("rsp_idle_zero", 64'({cpu_rsp_data, cpu_rsp_hit, cpu_rsp_err}), 64'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit rdy;
    int n;
    cpu_req_valid = 1'b1; cpu_req_write = w; cpu_req_addr = a; cpu_req_data = d;
    n = 0;
    do begin
      @(negedge clock); rdy = cpu_req_ready;
      @(posedge clock); n++;
    end while (!rdy && n < 100);
    chk("req_accepted", 64'(rdy), 64'(1));
    busy = 1'b1;
    #1;
    cpu_req_valid = 1'b0; cpu_req_data = $urandom;
  endtask

  task automatic run_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int hold);
    bit   res;
    int   exp_cw, exp_ops, n;
    mop_t eop;
    logic [DATA_W+1:0] e;
    res = is_res(a);
    eop.w = w; eop.a = a; eop.d = w ? d : '0;
    if (w) begin
      e = {DATA_W'(0), res, cache_stuck};
      exp_cw = cache_stuck ? 1 + CWAIT : (res ? 2 : 3);
      exp_ops = 1;
      ref_mem[a] = d;
      if (!res && !cache_stuck) add_line(a);
    end else if (res) begin
      e = {ref_mem[a], 2'b10}; exp_cw = 0; exp_ops = 0;
    end else if (mem_dead) begin
      e = {DATA_W'(0), 2'b01}; exp_cw = 0; exp_ops = 1;
    end else begin
      e = {ref_mem[a], 2'b00}; exp_cw = 3; exp_ops = 1;
      add_line(a);
    end
    exp_q.push_back(e);
    obs_q.delete();
    cw_cycles = 0;
    accept_req(w, a, d);
    n = 0;
    while (!cpu_rsp_valid && n < 300) begin
      @(posedge clock); #1; n++;
    end
    chk("rsp_arrives", 64'(cpu_rsp_valid), 64'(1));
    if (!w && res) chk("hit_latency", 64'(n), 64'(2));
    repeat (hold) @(posedge clock);
    if (hold > 0) #1;
    cpu_rsp_ready = 1'b1;
    @(posedge clock);
    busy = 1'b0;
    void'(exp_q.pop_front());
    #1;
    cpu_rsp_ready = 1'b0;
    chk("mem_op_count", 64'(obs_q.size()), 64'(exp_ops));
    if (exp_ops == 1 && obs_q.size() == 1)
      chk("mem_op", 64'({obs_q[0].w, obs_q[0].a, obs_q[0].w ? obs_q[0].d : DATA_W'(0)}), 64'(eop));
    chk("c_write_cycles", 64'(cw_cycles), 64'(exp_cw));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset_n = 1'b0; mon_on = 1'b0; busy = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0; cpu_req_data = '0;
    cpu_rsp_ready = 1'b0; c_hit = 1'b0; c_out_val = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    cv[0] = 1'b0; cv[1] = 1'b0; cvict = 0; cache_stuck = 1'b0;
    mem_dead = 1'b0; rdy_rand = 1'b0; lat_cfg = 0; rd_pend = 1'b0; rd_left = 0; rd_addr = '0;
    cw_cycles = 0; last_rsp = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h20] = 32'h1234_5678;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", 64'(cpu_req_ready), 64'(1));
    chk("rst_outputs", 64'({cpu_rsp_valid, cpu_rsp_hit, cpu_rsp_err, c_read, c_write, mem_req_valid, mem_req_write}), 64'(0));
    chk("rst_buses", 64'({cpu_rsp_data, c_addr, mem_req_addr}) | 64'(c_val) | 64'(mem_req_data), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    mon_on = 1'b1;

    // Store to empty cache: 3 write cycles, one posted memory write.
    run_req(1'b1, 8'h10, 32'hDEAD_BEEF, 0);
    chk("t1_cw3", 64'(cw_cycles), 64'(3));
    chk("t1_memwr", 64'({obs_q[0].w, obs_q[0].a, obs_q[0].d}), 64'({1'b1, 8'h10, 32'hDEAD_BEEF}));
    chk("t1_rsp", 64'(last_rsp), 64'({32'h0, 2'b00}));
    // Load hit on the stored line.
    run_req(1'b0, 8'h10, '0, 0);
    chk("t2_rsp", 64'(last_rsp), 64'({32'hDEAD_BEEF, 2'b10}));
    // Load miss with 4-cycle memory, then a repeat that hits.
    lat_cfg = 4;
    run_req(1'b0, 8'h20, '0, 0);
    chk("t3_rsp", 64'(last_rsp), 64'({32'h1234_5678, 2'b00}));
    chk("t3_memrd", 64'({obs_q[0].w, obs_q[0].a}), 64'({1'b0, 8'h20}));
    run_req(1'b0, 8'h20, '0, 0);
    chk("t3_rehit", 64'(last_rsp), 64'({32'h1234_5678, 2'b10}));
    lat_cfg = 0;
    // Memory never answers: timeout, no fill.
    mem_dead = 1'b1;
    run_req(1'b0, 8'h30, '0, 0);
    chk("t4_rsp", 64'(last_rsp), 64'({32'h0, 2'b01}));
    chk("t4_no_fill", 64'(cw_cycles), 64'(0));
    mem_dead = 1'b0;
    // Response held for 5 cycles.
    run_req(1'b0, 8'h10, '0, 5);
    chk("t5_rsp", 64'(last_rsp), 64'({32'hDEAD_BEEF, 2'b10}));
    // Cache never confirms the write: write timeout, store still posted.
    cache_stuck = 1'b1;
    run_req(1'b1, 8'h50, 32'hCAFE_F00D, 0);
    chk("t6_cw", 64'(cw_cycles), 64'(9));
    chk("t6_rsp", 64'(last_rsp), 64'({32'h0, 2'b01}));
    cache_stuck = 1'b0;

    // Randomized traffic over a small address pool to force evictions.
    rdy_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      run_req(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 5)), $urandom,
              int'($urandom_range(0, 3)));
    end
    rdy_rand = 1'b0;

    // Reset while waiting on memory: transaction abandoned, no response.
    mem_dead = 1'b1;
    obs_q.delete();
    accept_req(1'b0, 8'h60, '0);
    n = 0;
    while (obs_q.size() == 0 && n < 50) begin
      @(posedge clock); #1; n++;
    end
    chk("t7_memrd_seen", 64'(obs_q.size()), 64'(1));
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    busy = 1'b0;
    chk("t7_rst_outs", 64'({cpu_rsp_valid, c_read, c_write, mem_req_valid}), 64'(0));
    chk("t7_rst_ready", 64'(cpu_req_ready), 64'(1));
    chk("t7_rst_state", 64'(dbg_state), 64'(IDLE));
    mem_dead = 1'b0;
    ref_lines.delete();
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    chk("t7_ready_after", 64'(cpu_req_ready), 64'(1));
    run_req(1'b0, 8'h10, '0, 0);
    chk("t7_recover", 64'(last_rsp), 64'({32'hDEAD_BEEF, 2'b00}));

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
